// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter and pending-register scoreboard for the 32x64 register file.
// Define WB_RR_ARB_EN for round-robin arbitration; the default is fixed priority A over B.
module regfile_wb_arbiter #(
    parameter int DW = 64,
    parameter int AW = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 a_valid,
    input  logic [AW-1:0]        a_reg,
    input  logic signed [DW-1:0] a_data,
    output logic                 a_ready,
    input  logic                 b_valid,
    input  logic [AW-1:0]        b_reg,
    input  logic signed [DW-1:0] b_data,
    output logic                 b_ready,
    input  logic                 iss_valid,
    input  logic [AW-1:0]        iss_reg,
    input  logic [AW-1:0]        Rn,
    input  logic [AW-1:0]        Rm,
    output logic                 stall,
    output logic [AW-1:0]        WrReg,
    output logic signed [DW-1:0] WrData,
    output logic                 RfWr,
    output logic [31:0]          busy
);

    localparam logic [AW-1:0] ZERO_REG = AW'(31);

    logic                 a_grant, b_grant;
    logic [AW-1:0]        wr_reg_q, wr_reg_d;
    logic signed [DW-1:0] wr_data_q, wr_data_d;
    logic                 rf_wr_q, rf_wr_d;
    logic [31:0]          busy_q, busy_d;

`ifdef WB_RR_ARB_EN
    // ptr_q = 1 means B was granted last, so A wins the next contention.
    logic ptr_q;

    assign a_grant = a_valid && !rst && (!b_valid || ptr_q);
    assign b_grant = b_valid && !rst && (!a_valid || !ptr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b1;
        end else if (a_grant) begin
            ptr_q <= 1'b0;
        end else if (b_grant) begin
            ptr_q <= 1'b1;
        end
    end
`else
    assign a_grant = a_valid && !rst;
    assign b_grant = b_valid && !a_valid && !rst;
`endif

    always_comb begin
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        rf_wr_d   = 1'b0;
        if (a_grant) begin
            wr_reg_d  = a_reg;
            wr_data_d = a_data;
            rf_wr_d   = (a_reg != ZERO_REG);
        end else if (b_grant) begin
            wr_reg_d  = b_reg;
            wr_data_d = b_data;
            rf_wr_d   = (b_reg != ZERO_REG);
        end

        // Clear applies first so a same-edge issue to the same register keeps it pending.
        busy_d = busy_q;
        if (rf_wr_q) begin
            busy_d[wr_reg_q] = 1'b0;
        end
        if (iss_valid && (iss_reg != ZERO_REG)) begin
            busy_d[iss_reg] = 1'b1;
        end
        busy_d[31] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            rf_wr_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            rf_wr_q   <= rf_wr_d;
            busy_q    <= busy_d;
        end
    end

    assign a_ready = a_grant;
    assign b_ready = b_grant;
    assign stall   = busy_q[Rn] | busy_q[Rm];
    assign WrReg   = wr_reg_q;
    assign WrData  = wr_data_q;
    assign RfWr    = rf_wr_q;
    assign busy    = busy_q;

endmodule
